bdb_press_scheduler: RTL

Debounce scheduler for the DebouncedCounter design. It shares a single debounce timer among `NUM_BUTTONS` raw push-button inputs. Each button is synchronized and edge-detected, and pending presses are granted the timer round-robin. Every confirmed press produces a one-cycle `pressPulse[i]`, which feeds the counter datapath and the testbench responder.

---
 rtl/bdb_press_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bdb_press_scheduler.sv
// Round-robin debounce scheduler: one shared timer serves several synchronized
// push-button channels and emits a one-cycle pulse per confirmed press.
module bdb_press_scheduler #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_BUTTONS-1:0]         buttonRaw,
    output logic [NUM_BUTTONS-1:0]         pressPulse,
    output logic                           busy,
    output logic [$clog2(NUM_BUTTONS)-1:0] grantIdx
);

    localparam int IDX_W = $clog2(NUM_BUTTONS);
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0]     LAST_CHAN  = IDX_W'(NUM_BUTTONS - 1);

    typedef enum logic [1:0] {IDLE, TIMING, FIRE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]       grantIdx_q, grantIdx_d;
    logic [IDX_W-1:0]       lastGrant_q, lastGrant_d;
    logic [NUM_BUTTONS-1:0] pressPulse_q, pressPulse_d;
    logic                   busy_q, busy_d;

    logic [NUM_BUTTONS-1:0] sync1_q, btnSync_q, btnPrev_q;
    logic [NUM_BUTTONS-1:0] held_q, held_d;
    logic [NUM_BUTTONS-1:0] pending_q, pending_d;
    logic [NUM_BUTTONS-1:0] rise, grantClr, fireSet;

    logic [IDX_W-1:0]       sel;
    logic                   anyPending;

    assign rise = btnSync_q & ~btnPrev_q;

    // Search the pending set starting just above the previous owner, wrapping around.
    always_comb begin
        logic             found;
        int               idx;
        logic [IDX_W-1:0] cand;
        sel        = '0;
        found      = 1'b0;
        idx        = 0;
        cand       = '0;
        anyPending = |pending_q;
        for (int k = 1; k <= NUM_BUTTONS; k++) begin
            idx  = (int'(lastGrant_q) + k) % NUM_BUTTONS;
            cand = IDX_W'(idx);
            if (!found && pending_q[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        grantIdx_d   = grantIdx_q;
        lastGrant_d  = lastGrant_q;
        pressPulse_d = '0;
        grantClr     = '0;
        fireSet      = '0;
        case (state_q)
            IDLE: begin
                if (anyPending) begin
                    grantIdx_d    = sel;
                    grantClr[sel] = 1'b1;
                    timer_d       = '0;
                    state_d       = TIMING;
                end
            end
            TIMING: begin
                if (!btnSync_q[grantIdx_q]) begin
                    lastGrant_d = grantIdx_q;
                    state_d     = IDLE;
                end else if (timer_q == LAST_COUNT) begin
                    pressPulse_d[grantIdx_q] = 1'b1;
                    state_d                  = FIRE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FIRE: begin
                fireSet[grantIdx_q] = 1'b1;
                lastGrant_d         = grantIdx_q;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A low synchronized level drops both the pending request and the held marker.
    assign pending_d = (pending_q | (rise & ~held_q)) & btnSync_q & ~grantClr;
    assign held_d    = (held_q | fireSet) & btnSync_q;
    assign busy_d    = (state_d != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            grantIdx_q   <= '0;
            lastGrant_q  <= LAST_CHAN;
            pressPulse_q <= '0;
            busy_q       <= 1'b0;
            sync1_q      <= '0;
            btnSync_q    <= '0;
            btnPrev_q    <= '0;
            held_q       <= '0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            grantIdx_q   <= grantIdx_d;
            lastGrant_q  <= lastGrant_d;
            pressPulse_q <= pressPulse_d;
            busy_q       <= busy_d;
            sync1_q      <= buttonRaw;
            btnSync_q    <= sync1_q;
            btnPrev_q    <= btnSync_q;
            held_q       <= held_d;
            pending_q    <= pending_d;
        end
    end

    assign pressPulse = pressPulse_q;
    assign busy       = busy_q;
    assign grantIdx   = grantIdx_q;

endmodule
